// File: rtl/serial_tx_framer_if.sv
// serial_tx_framer_if
//   Word handshake between a packet source and serial_tx_framer.
//   Signals:
//     in_valid  source has a word on data_in
//     in_ready  framer can accept a word (framer idle)
//     data_in   DATA_W-bit word, sampled by the framer on the accept edge
//   Modports:
//     master  packet source side
//     slave   framer side
interface serial_tx_framer_if #(
  parameter int DATA_W = 7
);
  logic              in_valid;
  logic              in_ready;
  logic [DATA_W-1:0] data_in;

  modport master (output in_valid, output data_in, input in_ready);
  modport slave  (input in_valid, input data_in, output in_ready);
endinterface

// File: rtl/serial_tx_framer.sv
// serial_tx_framer
//   Serial frame transmitter. Takes a parallel word over a valid/ready
//   handshake and sends it LSB-first as: start bit (0), DATA_W data bits,
//   optional even/odd parity bit, STOP_BITS stop bits (1). Each bit is held
//   on the line for CLKS_PER_BIT clocks. The idle line level is 1.
//   Parameters:
//     DATA_W        data bits per frame, 5..9
//     PARITY_MODE   0 = none, 1 = even, 2 = odd
//     STOP_BITS     1 or 2
//     CLKS_PER_BIT  clocks per bit-time, >= 1
//   Ports:
//     clk         clock, all logic on the rising edge
//     rstn        synchronous active-low reset
//     bus         slave side of the word handshake (in_valid/in_ready/data_in)
//     serial_out  registered serial line
//     busy        high while a frame is in flight
//     frame_done  one-cycle pulse when the last stop bit completes
module serial_tx_framer #(
  parameter int DATA_W       = 7,
  parameter int PARITY_MODE  = 1,
  parameter int STOP_BITS    = 1,
  parameter int CLKS_PER_BIT = 1
) (
  input  logic              clk,
  input  logic              rstn,
  serial_tx_framer_if.slave bus,
  output logic              serial_out,
  output logic              busy,
  output logic              frame_done
);

  // A one-clock bit-time still needs a 1-bit counter so the wrap compare
  // stays well formed.
  localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  // DATA_W >= 5 gives at least 3 bits, which also covers the stop-bit count.
  localparam int BIT_W = $clog2(DATA_W);

  localparam logic [CNT_W-1:0] LAST_CLK  = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0] LAST_DATA = BIT_W'(DATA_W - 1);
  localparam logic [BIT_W-1:0] LAST_STOP = BIT_W'(STOP_BITS - 1);
  localparam bit               HAS_PAR   = (PARITY_MODE != 0);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  generate
    if (DATA_W < 5 || DATA_W > 9 || PARITY_MODE < 0 || PARITY_MODE > 2 ||
        (STOP_BITS != 1 && STOP_BITS != 2) || CLKS_PER_BIT < 1) begin : g_bad_params
      $error("serial_tx_framer: unsupported parameter combination");
    end
  endgenerate

  logic [2:0]        state;
  logic [CNT_W-1:0]  clk_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic              parity_bit;
  logic              bit_end;
  logic              word_parity;

  // in_ready is purely a function of state so a continuously presented word
  // is taken on the very first idle edge.
  assign bus.in_ready = (state == S_IDLE);
  assign busy         = (state != S_IDLE);
  assign bit_end      = (clk_cnt == LAST_CLK);
  assign word_parity  = (PARITY_MODE == 2) ? ~(^bus.data_in) : ^bus.data_in;

  // Frame sequencer. serial_out is updated on the same edge that enters a
  // new bit so the line is always a clean register output. The shift
  // register exposes the current data bit at [0]; [1] is the next one.
  // bit_cnt is reused to count stop bits.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      state      <= S_IDLE;
      clk_cnt    <= '0;
      bit_cnt    <= '0;
      shift_reg  <= '0;
      parity_bit <= 1'b0;
      serial_out <= 1'b1;
      frame_done <= 1'b0;
    end else begin
      frame_done <= 1'b0;
      if (state != S_IDLE) begin
        clk_cnt <= bit_end ? '0 : clk_cnt + 1'b1;
      end
      case (state)
        S_IDLE: begin
          if (bus.in_valid) begin
            shift_reg  <= bus.data_in;
            parity_bit <= word_parity;
            state      <= S_START;
            serial_out <= 1'b0;
            clk_cnt    <= '0;
            bit_cnt    <= '0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state      <= S_DATA;
            serial_out <= shift_reg[0];
            bit_cnt    <= '0;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            if (bit_cnt == LAST_DATA) begin
              bit_cnt <= '0;
              if (HAS_PAR) begin
                state      <= S_PARITY;
                serial_out <= parity_bit;
              end else begin
                state      <= S_STOP;
                serial_out <= 1'b1;
              end
            end else begin
              bit_cnt    <= bit_cnt + 1'b1;
              shift_reg  <= shift_reg >> 1;
              serial_out <= shift_reg[1];
            end
          end
        end
        S_PARITY: begin
          if (bit_end) begin
            state      <= S_STOP;
            serial_out <= 1'b1;
            bit_cnt    <= '0;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (bit_cnt == LAST_STOP) begin
              state      <= S_IDLE;
              frame_done <= 1'b1;
              bit_cnt    <= '0;
            end else begin
              bit_cnt <= bit_cnt + 1'b1;
            end
          end
        end
        default: begin
          state      <= S_IDLE;
          serial_out <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_tx_framer.sv
// tb_serial_tx_framer
//   Drives three framer configurations from one shared stimulus stream and
//   compares every cycle against a frame model that derives the expected
//   line level from the bit position inside the frame. Directed sequences
//   cover the fixed example frames, back-to-back sends, mid-frame reset and
//   input changes while busy.
`timescale 1ns/1ps
module tb_serial_tx_framer;

  localparam int A_DW = 7, A_PM = 1, A_SB = 1, A_CPB = 1;
  localparam int B_DW = 8, B_PM = 2, B_SB = 1, B_CPB = 4;
  localparam int C_DW = 7, C_PM = 0, C_SB = 2, C_CPB = 1;

  localparam int DW_T  [3] = '{A_DW,  B_DW,  C_DW};
  localparam int PM_T  [3] = '{A_PM,  B_PM,  C_PM};
  localparam int SB_T  [3] = '{A_SB,  B_SB,  C_SB};
  localparam int CPB_T [3] = '{A_CPB, B_CPB, C_CPB};

  typedef struct {
    logic       valid;
    logic [8:0] data;
    logic       exp_ser;
    logic       exp_busy;
    logic       exp_done;
  } vec_t;

  logic       clk = 1'b0;
  logic       rstn = 1'b0;
  logic       in_valid = 1'b0;
  logic [8:0] data_in = '0;

  logic ser_a, ser_b, ser_c;
  logic busy_a, busy_b, busy_c;
  logic done_a, done_b, done_c;
  logic [2:0] ser, bsy, dne, rdy;

  int checks = 0;
  int failures = 0;
  logic chk_en = 1'b0;

  // Frame model state: per configuration, whether a frame is in flight,
  // the word latched at accept, and cycles elapsed since the accept edge.
  logic [2:0] m_busy;
  logic [2:0] m_done;
  logic [8:0] m_word [3];
  int         m_k [3];

  int           done_cnt [3];
  int           done_at [3];
  int           busy_cnt [3];
  logic [127:0] line_hist [3];

  serial_tx_framer_if #(.DATA_W(A_DW)) bus_a ();
  serial_tx_framer_if #(.DATA_W(B_DW)) bus_b ();
  serial_tx_framer_if #(.DATA_W(C_DW)) bus_c ();

  assign bus_a.in_valid = in_valid;
  assign bus_b.in_valid = in_valid;
  assign bus_c.in_valid = in_valid;
  assign bus_a.data_in  = data_in[A_DW-1:0];
  assign bus_b.data_in  = data_in[B_DW-1:0];
  assign bus_c.data_in  = data_in[C_DW-1:0];

  serial_tx_framer #(.DATA_W(A_DW), .PARITY_MODE(A_PM), .STOP_BITS(A_SB), .CLKS_PER_BIT(A_CPB)) dut_a (
    .clk(clk), .rstn(rstn), .bus(bus_a), .serial_out(ser_a), .busy(busy_a), .frame_done(done_a));
  serial_tx_framer #(.DATA_W(B_DW), .PARITY_MODE(B_PM), .STOP_BITS(B_SB), .CLKS_PER_BIT(B_CPB)) dut_b (
    .clk(clk), .rstn(rstn), .bus(bus_b), .serial_out(ser_b), .busy(busy_b), .frame_done(done_b));
  serial_tx_framer #(.DATA_W(C_DW), .PARITY_MODE(C_PM), .STOP_BITS(C_SB), .CLKS_PER_BIT(C_CPB)) dut_c (
    .clk(clk), .rstn(rstn), .bus(bus_c), .serial_out(ser_c), .busy(busy_c), .frame_done(done_c));

  assign ser = {ser_c, ser_b, ser_a};
  assign bsy = {busy_c, busy_b, busy_a};
  assign dne = {done_c, done_b, done_a};
  assign rdy = {bus_c.in_ready, bus_b.in_ready, bus_a.in_ready};

  always #5 clk = ~clk;

  function automatic int frame_len(input int d);
    return CPB_T[d] * (1 + DW_T[d] + ((PM_T[d] != 0) ? 1 : 0) + SB_T[d]);
  endfunction

  // Line level k cycles after the accept edge: which bit of the frame we
  // are in is simply k / CLKS_PER_BIT.
  function automatic logic exp_bit(input int d, input logic [8:0] w, input int k);
    int   idx;
    logic p;
    idx = k / CPB_T[d];
    p = 1'b0;
    for (int i = 0; i < DW_T[d]; i++) p ^= w[i];
    if (PM_T[d] == 2) p = ~p;
    if (idx == 0) return 1'b0;
    if (idx <= DW_T[d]) return w[idx-1];
    if (PM_T[d] != 0 && idx == DW_T[d] + 1) return p;
    return 1'b1;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    data_in  = v.data;
    in_valid = v.valid;
    @(negedge clk);
  endtask

  task automatic waitIdle(input int limit);
    int n;
    n = 0;
    while (bsy !== 3'b000 && n < limit) begin
      @(negedge clk);
      n++;
    end
    checkOutput("wait for all idle", 64'(bsy), 64'd0);
  endtask

  task automatic sendWord(input logic [8:0] w);
    data_in  = w;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic runWatch(input int cycles);
    for (int d = 0; d < 3; d++) begin
      done_cnt[d]  = 0;
      done_at[d]   = -1;
      busy_cnt[d]  = 0;
      line_hist[d] = '1;
    end
    for (int i = 0; i < cycles; i++) begin
      for (int d = 0; d < 3; d++) begin
        line_hist[d][i] = ser[d];
        if (bsy[d]) busy_cnt[d]++;
        if (dne[d]) begin
          done_cnt[d]++;
          if (done_at[d] < 0) done_at[d] = i;
        end
      end
      @(negedge clk);
    end
  endtask

  // Reference frame model, advanced on the same edges the DUTs see.
  always @(posedge clk) begin
    for (int d = 0; d < 3; d++) begin
      if (!rstn) begin
        m_busy[d] <= 1'b0;
        m_done[d] <= 1'b0;
        m_k[d]    <= 0;
      end else if (!m_busy[d]) begin
        m_done[d] <= 1'b0;
        if (in_valid) begin
          m_busy[d] <= 1'b1;
          m_word[d] <= data_in;
          m_k[d]    <= 0;
        end
      end else if (m_k[d] + 1 == frame_len(d)) begin
        m_busy[d] <= 1'b0;
        m_done[d] <= 1'b1;
      end else begin
        m_k[d] <= m_k[d] + 1;
      end
    end
  end

  // Per-cycle comparison of every configuration against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      for (int d = 0; d < 3; d++) begin
        checkOutput($sformatf("dut%0d serial_out t=%0t", d, $time), 64'(ser[d]),
                    64'(m_busy[d] ? exp_bit(d, m_word[d], m_k[d]) : 1'b1));
        checkOutput($sformatf("dut%0d busy t=%0t", d, $time), 64'(bsy[d]), 64'(m_busy[d]));
        checkOutput($sformatf("dut%0d frame_done t=%0t", d, $time), 64'(dne[d]), 64'(m_done[d]));
        checkOutput($sformatf("dut%0d in_ready t=%0t", d, $time), 64'(rdy[d]), 64'(!m_busy[d]));
      end
    end
  end

  initial begin
    #1_000_000;
    failures++;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    vec_t        vecs [12];
    logic [8:0]  words [3];
    int          idx, ready_hi, done_hi, idle_hi;

    // Default config, word 7'h55: line 0,1,0,1,0,1,0,1,0,1 then idle.
    vecs[0]  = '{1'b1, 9'h055, 1'b0, 1'b1, 1'b0};
    vecs[1]  = '{1'b0, 9'h1FF, 1'b1, 1'b1, 1'b0};
    vecs[2]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0};
    vecs[3]  = '{1'b0, 9'h1FF, 1'b1, 1'b1, 1'b0};
    vecs[4]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0};
    vecs[5]  = '{1'b0, 9'h1FF, 1'b1, 1'b1, 1'b0};
    vecs[6]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0};
    vecs[7]  = '{1'b0, 9'h1FF, 1'b1, 1'b1, 1'b0};
    vecs[8]  = '{1'b0, 9'h000, 1'b0, 1'b1, 1'b0};
    vecs[9]  = '{1'b0, 9'h000, 1'b1, 1'b1, 1'b0};
    vecs[10] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 9'h000, 1'b1, 1'b0, 1'b0};

    rstn = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      checkOutput($sformatf("reset dut%0d serial_out", d), 64'(ser[d]), 64'd1);
      checkOutput($sformatf("reset dut%0d busy", d), 64'(bsy[d]), 64'd0);
      checkOutput($sformatf("reset dut%0d frame_done", d), 64'(dne[d]), 64'd0);
      checkOutput($sformatf("reset dut%0d in_ready", d), 64'(rdy[d]), 64'd1);
    end
    rstn   = 1'b1;
    chk_en = 1'b1;

    $display("[TB] table: default frame 7'h55");
    for (int i = 0; i < 12; i++) begin
      applyStimulus(vecs[i]);
      checkOutput($sformatf("table[%0d] serial_out", i), 64'(ser_a), 64'(vecs[i].exp_ser));
      checkOutput($sformatf("table[%0d] busy", i), 64'(busy_a), 64'(vecs[i].exp_busy));
      checkOutput($sformatf("table[%0d] frame_done", i), 64'(done_a), 64'(vecs[i].exp_done));
    end

    $display("[TB] no parity, two stop bits, word 0");
    waitIdle(100);
    sendWord(9'h000);
    runWatch(16);
    checkOutput("nopar line", 64'(line_hist[2][9:0]), 64'h300);
    checkOutput("nopar busy cycles", 64'(busy_cnt[2]), 64'd10);
    checkOutput("nopar done cycle", 64'(done_at[2]), 64'd10);
    checkOutput("nopar done count", 64'(done_cnt[2]), 64'd1);

    $display("[TB] odd parity, 8 bits, 4 clocks per bit, word A3");
    waitIdle(100);
    sendWord(9'h0A3);
    runWatch(50);
    checkOutput("odd line", 64'(line_hist[1][43:0]), 64'hFFF0F000FF0);
    checkOutput("odd parity bit", 64'(line_hist[1][37]), 64'd1);
    checkOutput("odd frame length", 64'(done_at[1]), 64'd44);
    checkOutput("odd done count", 64'(done_cnt[1]), 64'd1);
    checkOutput("odd busy cycles", 64'(busy_cnt[1]), 64'd44);

    $display("[TB] back-to-back words 12 34 56");
    waitIdle(100);
    words[0] = 9'h012; words[1] = 9'h034; words[2] = 9'h056;
    idx = 0; ready_hi = 0; done_hi = 0; idle_hi = 0;
    for (int c = 0; c < 34; c++) begin
      if (c >= 1 && c <= 32 && !busy_a) idle_hi++;
      if (done_a) done_hi++;
      if (bus_a.in_ready && idx < 3) begin
        data_in  = words[idx];
        in_valid = 1'b1;
        idx++;
        ready_hi++;
      end else if (idx == 3 && !bus_a.in_ready) begin
        in_valid = 1'b0;
      end
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("b2b frames accepted", 64'(ready_hi), 64'd3);
    checkOutput("b2b done pulses", 64'(done_hi), 64'd3);
    checkOutput("b2b idle gap cycles", 64'(idle_hi), 64'd2);

    $display("[TB] reset during data bit 3 of 7F");
    waitIdle(100);
    sendWord(9'h07F);
    repeat (4) @(negedge clk);
    checkOutput("pre-reset data bit 3", 64'(ser_a), 64'd1);
    checkOutput("pre-reset busy", 64'(busy_a), 64'd1);
    rstn = 1'b0;
    @(negedge clk);
    rstn = 1'b1;
    checkOutput("post-reset serial_out", 64'(ser_a), 64'd1);
    checkOutput("post-reset busy", 64'(busy_a), 64'd0);
    runWatch(12);
    checkOutput("post-reset no frame_done", 64'(done_cnt[0]), 64'd0);
    waitIdle(100);
    sendWord(9'h02C);
    runWatch(12);
    checkOutput("after-reset line", 64'(line_hist[0][9:0]), 64'h358);
    checkOutput("after-reset done cycle", 64'(done_at[0]), 64'd10);

    $display("[TB] inputs toggled mid-frame, word 4B");
    waitIdle(100);
    sendWord(9'h04B);
    line_hist[0] = '1;
    for (int i = 0; i < 10; i++) begin
      line_hist[0][i] = ser_a;
      data_in  = 9'($urandom);
      in_valid = 1'($urandom_range(0, 1));
      @(negedge clk);
    end
    in_valid = 1'b0;
    checkOutput("toggle line", 64'(line_hist[0][9:0]), 64'h296);
    checkOutput("toggle data bits", 64'(line_hist[0][7:1]), 64'h4B);

    $display("[TB] random traffic");
    waitIdle(100);
    for (int i = 0; i < 3000; i++) begin
      in_valid = ($urandom_range(0, 2) != 0);
      data_in  = 9'($urandom);
      rstn     = ($urandom_range(0, 299) != 0);
      @(negedge clk);
    end
    rstn     = 1'b1;
    in_valid = 1'b0;
    waitIdle(200);
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
